uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Serial UART receiver: 8N1-style frames (1 start bit, DATA_BITS data bits LSB first, 1 stop bit), no parity.
- Samples an asynchronous rx_serial line in the PCLK domain and reports each byte with a one-cycle done pulse.
- Sits behind the APB UART register block, which drives rx_en/rx_rst and reads rx_data and the status flags.

Parameters:
- BAUD_RATE, 9600, line rate in bit/s
- CLK_FREQ, 100_000_000, PCLK frequency in Hz
- DATA_BITS, 8, data bits per frame
- Derived localparam CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division (10416 at defaults).
- Derived localparam HALF_BIT = CLKS_PER_BIT/2 (5208 at defaults).

Ports:
- PCLK  in  1  system clock, rising edge
- PRESETn  in  1  reset
- rx_en  in  1  receiver enable
- rx_rst  in  1  synchronous soft reset, active high
- rx_serial  in  1  serial line, idle high, asynchronous to PCLK
- rx_done  out  1  one-cycle pulse: valid frame received
- rx_busy  out  1  high while a frame is in progress
- rx_error  out  1  framing error flag
- rx_data  out  DATA_BITS  last correctly received word

Behaviour:
- Clock and reset (Already decided): one clock; reset is asynchronous and active-low. The clock port is PCLK and the reset port is PRESETn.
- Reset values:
  - rx_done=0, rx_busy=0, rx_error=0, rx_data=0.
  - State IDLE, counters 0, synchronizer flops=1.
- rx_rst=1 is a synchronous soft reset: same values as PRESETn reset, applied on the next PCLK edge. It takes priority over all other activity, including mid-frame.
- Input path:
  - rx_serial passes through a 2-flop synchronizer initialised to 1.
  - All decisions use the synchronized value.
- States: IDLE, START, DATA, STOP, DONE.
- IDLE:
  - Stays in IDLE while rx_en=0.
  - With rx_en=1, a synchronized low moves to START and clears the bit counter.
- START:
  - Count HALF_BIT clocks, then re-sample.
  - If low: go to DATA, clear the clock counter, clear rx_error.
  - If high: false start, return to IDLE with no flags changed.
- DATA:
  - Every CLKS_PER_BIT clocks, sample one bit into a shift register, LSB first: bit i lands in position i.
  - After DATA_BITS samples, go to STOP.
- STOP:
  - After CLKS_PER_BIT clocks, sample the stop bit.
  - If 1: load rx_data from the shift register, then go to DONE.
  - If 0: set rx_error, leave rx_data unchanged, return to IDLE, and do not pulse rx_done.
- DONE: rx_done=1 for exactly one cycle, then IDLE.
- rx_busy: high in START, DATA and STOP; low in IDLE and DONE.
- rx_error is sticky. It is cleared only by reset, rx_rst, or a confirmed start bit of the next frame.
- rx_data holds its value until the next valid frame.
- rx_en deasserted mid-frame: the current frame completes normally. rx_en only gates new start detection.
- Latency: from the falling edge of the start bit on rx_serial to the rx_done pulse is about 2 + HALF_BIT + (DATA_BITS+1)·CLKS_PER_BIT + 2 cycles, i.e. about 9.5 bit periods.
- Back-to-back frames: a new start bit is accepted in the first cycle back in IDLE, including immediately after the stop sample. The block needs no extra idle bit between frames.
- Counter width: clog2(CLKS_PER_BIT) bits for the clock counter, clog2(DATA_BITS+1) bits for the bit counter.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, DONE)
  - a function computing CLKS_PER_BIT from CLK_FREQ and BAUD_RATE, shared with the transmitter
- One natural sub-module: uart_rx_sync, the 2-flop synchronizer with reset value 1.
- The baud counter and FSM stay in the top module.

Test Plan:
- Reset and enable:
  - Stimulus: PRESETn=0 for 200 ns, then rx_en=1 and a 100 ns rx_rst pulse.
  - Required: all outputs 0, rx_busy=0 while the line idles high.
- Back-to-back frames:
  - Stimulus: frames 0x16, 0x32, 0xAF at 104166.67 ns per bit, with one idle bit between frames.
  - Required: three rx_done pulses, each one cycle wide; rx_data = 0x16, 0x32, 0xAF in turn; rx_error stays 0; rx_busy high during each frame.
- Framing error:
  - Stimulus: send 0x55 with the stop bit driven low.
  - Required: rx_error=1, no rx_done pulse, rx_data keeps its previous value.
  - Follow-up: send 0xA5 correctly. Required: rx_error clears at the start bit, rx_data=0xA5.
- False start:
  - Stimulus: a 2 µs low glitch on an idle line.
  - Required: rx_busy rises then returns to 0 within HALF_BIT+3 cycles; no rx_done, no rx_error.
- rx_en low:
  - Stimulus: hold rx_en=0 and send 0x3C.
  - Required: rx_busy stays 0, no rx_done.
  - Follow-up: assert rx_en=1 mid-frame. Required: the remaining falling edges are not mis-framed into a valid frame, or any frame accepted is flagged as described above.
- Soft reset mid-frame:
  - Stimulus: pulse rx_rst during data bit 4.
  - Required: rx_busy=0 the next cycle, rx_data=0, no rx_done.
  - Follow-up: send a subsequent 0x81 frame. Required: it is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divisor helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StDone
  } uart_state_e;

  // Integer divisor; any remainder shows up as a small baud error.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so that the idle line never looks like a start bit.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic serial_i,
  output logic serial_o
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], serial_i};
    if (clr_i) begin
      sync_d = 2'b11;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign serial_o = sync_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit, no parity.
// Reports each good frame with a one-cycle rx_done pulse; framing errors set a sticky flag.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 rx_en,
  input  logic                 rx_rst,
  input  logic                 rx_serial,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 rx_error,
  output logic [DATA_BITS-1:0] rx_data
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W        = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

  logic rx_sync;

  uart_rx_sync u_sync (
    .clk_i    (PCLK),
    .rst_ni   (PRESETn),
    .clr_i    (rx_rst),
    .serial_i (rx_serial),
    .serial_o (rx_sync)
  );

  uart_state_e          state_q,   state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 done_q,    done_d;
  logic                 busy_q,    busy_d;
  logic                 error_q,   error_d;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    error_d   = error_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // rx_en only gates new start detection; frames in flight always complete.
        if (rx_en && !rx_sync) begin
          state_d   = StStart;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end

      StStart: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          if (!rx_sync) begin
            state_d = StData;
            error_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StData: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          // Shift in at the MSB so the first bit ends up in position 0.
          shift_d = shift_q >> 1;
          shift_d[DATA_BITS-1] = rx_sync;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == DATA_LAST) begin
            state_d = StStop;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_sync) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            error_d = 1'b1;
            state_d = StIdle;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StStart) || (state_d == StData) || (state_d == StStop);

    // Soft reset overrides everything, including a frame in progress.
    if (rx_rst) begin
      state_d   = StIdle;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      shift_d   = '0;
      data_d    = '0;
      error_d   = 1'b0;
      done_d    = 1'b0;
      busy_d    = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
    end
  end

  assign rx_done  = done_q;
  assign rx_busy  = busy_q;
  assign rx_error = error_q;
  assign rx_data  = data_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at a fast baud rate (16 clocks per bit).
// Directed vector table, hand-written corner sequences and a randomized frame stream.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int unsigned CLK_FREQ  = 100_000_000;
  localparam int unsigned BAUD_RATE = 6_250_000;
  localparam int unsigned DATA_BITS = 8;
  localparam int          CPB       = CLK_FREQ / BAUD_RATE;
  localparam int          HALF      = CPB / 2;
  localparam int          BIT_NS    = 10 * CPB;

  logic                 PCLK = 1'b0;
  logic                 PRESETn;
  logic                 rx_en;
  logic                 rx_rst;
  logic                 rx_serial;
  logic                 rx_done;
  logic                 rx_busy;
  logic                 rx_error;
  logic [DATA_BITS-1:0] rx_data;

  uart_rx_core #(
    .BAUD_RATE (BAUD_RATE),
    .CLK_FREQ  (CLK_FREQ),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .rx_en     (rx_en),
    .rx_rst    (rx_rst),
    .rx_serial (rx_serial),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .rx_error  (rx_error),
    .rx_data   (rx_data)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference model: bytes that must appear, in order, on rx_done pulses.
  logic [7:0] exp_q[$];
  int         done_cnt    = 0;
  int         busy_cycles = 0;
  bit         allow_any   = 1'b0;
  logic       prev_done   = 1'b0;

  always @(negedge PCLK) begin
    if (rx_busy) busy_cycles++;
    if (rx_done) begin
      done_cnt++;
      check("done_width", 32'(prev_done), 32'(0));
      if (!allow_any) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(1), 32'(0));
        end else begin
          check("done_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_done = rx_done;
  end

  task automatic send_frame(input logic [7:0] b, input bit stop, input int idle);
    rx_serial = 1'b0;
    #(BIT_NS);
    for (int k = 0; k < 8; k++) begin
      rx_serial = b[k];
      #(BIT_NS);
    end
    rx_serial = stop;
    #(BIT_NS);
    rx_serial = 1'b1;
    #(idle * BIT_NS);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         en;
    int         exp_done;
    logic [7:0] exp_data;
    bit         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         d0;
    bit         model_err;
    bit         rose;
    bit         fell;
    logic [7:0] last_good;
    logic [7:0] b;
    bit         bad;
    int         idle;
    int         n_good;

    vecs[0] = '{8'h16, 1'b1, 1'b1, 1, 8'h16, 1'b0};
    vecs[1] = '{8'h32, 1'b1, 1'b1, 1, 8'h32, 1'b0};
    vecs[2] = '{8'hAF, 1'b1, 1'b1, 1, 8'hAF, 1'b0};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 0, 8'hAF, 1'b1};
    vecs[4] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 1'b0};
    vecs[5] = '{8'h3C, 1'b1, 1'b0, 0, 8'hA5, 1'b0};

    // Reset and enable
    PRESETn   = 1'b0;
    rx_en     = 1'b0;
    rx_rst    = 1'b0;
    rx_serial = 1'b1;
    #100;
    check("reset_outputs", 32'({rx_done, rx_busy, rx_error, rx_data}), 32'(0));
    #100;
    PRESETn = 1'b1;
    @(negedge PCLK);
    rx_en  = 1'b1;
    rx_rst = 1'b1;
    #100;
    rx_rst = 1'b0;
    busy_cycles = 0;
    repeat (20) @(negedge PCLK);
    check("idle_busy_cycles", 32'(busy_cycles), 32'(0));
    check("post_rst_outputs", 32'({rx_done, rx_busy, rx_error, rx_data}), 32'(0));

    // Directed vector table: back-to-back frames, framing error, recovery, rx_en low
    model_err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rx_en       = vecs[i].en;
      d0          = done_cnt;
      busy_cycles = 0;
      if (vecs[i].exp_done != 0) exp_q.push_back(vecs[i].exp_data);
      @(negedge PCLK);
      #2;
      fork
        send_frame(vecs[i].data, vecs[i].stop, 1);
        begin
          #(2 * BIT_NS);
          check("mid_busy", 32'(rx_busy), 32'(vecs[i].en));
          check("mid_error", 32'(rx_error), 32'(vecs[i].en ? 1'b0 : model_err));
        end
      join
      #(BIT_NS);
      check("vec_done_count", 32'(done_cnt - d0), 32'(vecs[i].exp_done));
      check("vec_data", 32'(rx_data), 32'(vecs[i].exp_data));
      check("vec_error", 32'(rx_error), 32'(vecs[i].exp_err));
      check("vec_busy_idle", 32'(rx_busy), 32'(0));
      check("vec_busy_seen", 32'(busy_cycles > 0), 32'(vecs[i].en));
      model_err = vecs[i].exp_err;
    end

    // rx_en raised mid-frame: any frame accepted is not checked, only recovery
    allow_any = 1'b1;
    rx_en     = 1'b0;
    @(negedge PCLK);
    #2;
    fork
      send_frame(8'h3C, 1'b1, 2);
      begin
        #(3 * BIT_NS + BIT_NS / 2);
        rx_en = 1'b1;
      end
    join
    #(8 * BIT_NS);
    allow_any = 1'b0;
    check("en_mid_busy_idle", 32'(rx_busy), 32'(0));

    // Soft reset during data bit 4
    d0 = done_cnt;
    @(negedge PCLK);
    #2;
    fork
      send_frame(8'hF5, 1'b1, 1);
      begin
        #(5 * BIT_NS + BIT_NS / 2);
        @(negedge PCLK);
        check("pre_rst_busy", 32'(rx_busy), 32'(1));
        rx_rst = 1'b1;
        @(negedge PCLK);
        rx_rst = 1'b0;
        check("rst_busy", 32'(rx_busy), 32'(0));
        check("rst_data", 32'(rx_data), 32'(0));
        check("rst_error", 32'(rx_error), 32'(0));
      end
    join
    #(BIT_NS);
    check("rst_no_done", 32'(done_cnt - d0), 32'(0));
    d0 = done_cnt;
    exp_q.push_back(8'h81);
    @(negedge PCLK);
    #2;
    send_frame(8'h81, 1'b1, 1);
    #(BIT_NS);
    check("after_rst_done", 32'(done_cnt - d0), 32'(1));
    check("after_rst_data", 32'(rx_data), 32'(8'h81));
    check("after_rst_error", 32'(rx_error), 32'(0));

    // False start: glitch shorter than half a bit
    d0 = done_cnt;
    @(negedge PCLK);
    #2 rx_serial = 1'b0;
    #30 rx_serial = 1'b1;
    rose = 1'b0;
    for (int k = 0; k < 8 && !rose; k++) begin
      @(negedge PCLK);
      if (rx_busy) rose = 1'b1;
    end
    fell = 1'b0;
    for (int k = 0; k < HALF + 3 && !fell; k++) begin
      @(negedge PCLK);
      if (!rx_busy) fell = 1'b1;
    end
    check("false_start_rose", 32'(rose), 32'(1));
    check("false_start_fell", 32'(fell), 32'(1));
    #(BIT_NS);
    check("false_start_no_done", 32'(done_cnt - d0), 32'(0));
    check("false_start_no_error", 32'(rx_error), 32'(0));
    check("false_start_data", 32'(rx_data), 32'(8'h81));

    // Randomized stream against the model
    last_good = 8'h81;
    model_err = 1'b0;
    n_good    = 0;
    d0        = done_cnt;
    @(negedge PCLK);
    #2;
    for (int i = 0; i < 24; i++) begin
      b    = 8'($urandom);
      bad  = ($urandom_range(0, 4) == 0);
      idle = bad ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
      if (!bad) begin
        exp_q.push_back(b);
        last_good = b;
        n_good++;
      end
      model_err = bad;
      send_frame(b, !bad, idle);
    end
    #(2 * BIT_NS);
    check("rand_done_count", 32'(done_cnt - d0), 32'(n_good));
    check("rand_data", 32'(rx_data), 32'(last_good));
    check("rand_error", 32'(rx_error), 32'(model_err));
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
